// File: rtl/uart_cfg.sv
// uart_cfg: configurable UART with independent oversampled TX/RX dividers.
// Optional parity is built only when UART_CFG_PARITY_EN is defined.
`default_nettype none

module uart_cfg #(
  parameter int CLOCK_DIVIDE = 109,
  parameter int OVERSAMPLE   = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int DIV_W = $clog2(CLOCK_DIVIDE);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [OS_W-1:0]  OS_MAX  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  OS_HALF = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_BITS - 1);

  logic par_sel, par_odd;
`ifdef UART_CFG_PARITY_EN
  assign par_sel = (parity_mode == 2'b01) || (parity_mode == 2'b10);
  assign par_odd = (parity_mode == 2'b10);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign par_sel = 1'b0;
  assign par_odd = 1'b0;
`endif

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_IDLE} rx_state_t;

  tx_state_t            tx_state;
  logic [DIV_W-1:0]     tx_div;
  logic [OS_W-1:0]      tx_tcnt;
  logic [BIT_W-1:0]     tx_bit;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par_en, tx_par_bit, tx_stop2_r, tx_stop_second;
  logic                 tx_tick, tx_bit_end;

  assign tx_tick    = (tx_div == DIV_MAX);
  assign tx_bit_end = tx_tick && (tx_tcnt == OS_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state       <= TX_IDLE;
      tx             <= 1'b1;
      tx_ready       <= 1'b1;
      tx_div         <= '0;
      tx_tcnt        <= '0;
      tx_bit         <= '0;
      tx_shift       <= '0;
      tx_par_en      <= 1'b0;
      tx_par_bit     <= 1'b0;
      tx_stop2_r     <= 1'b0;
      tx_stop_second <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      if (tx_valid && tx_ready) begin
        tx_state       <= TX_START;
        tx             <= 1'b0;
        tx_ready       <= 1'b0;
        tx_div         <= '0;
        tx_tcnt        <= '0;
        tx_shift       <= tx_data;
        tx_par_en      <= par_sel;
        tx_par_bit     <= (^tx_data) ^ par_odd;
        tx_stop2_r     <= stop2;
        tx_stop_second <= 1'b0;
      end
    end else begin
      tx_div <= tx_tick ? '0 : tx_div + 1'b1;
      if (tx_tick) tx_tcnt <= (tx_tcnt == OS_MAX) ? '0 : tx_tcnt + 1'b1;
      if (tx_bit_end) begin
        case (tx_state)
          TX_START: begin
            tx_state <= TX_DATA;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
            tx_bit   <= '0;
          end
          TX_DATA: begin
            if (tx_bit == BIT_MAX) begin
              tx_state <= tx_par_en ? TX_PARITY : TX_STOP;
              tx       <= tx_par_en ? tx_par_bit : 1'b1;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end
          TX_PARITY: begin
            tx_state <= TX_STOP;
            tx       <= 1'b1;
          end
          TX_STOP: begin
            if (tx_stop2_r && !tx_stop_second) begin
              tx_stop_second <= 1'b1;
            end else begin
              tx_state <= TX_IDLE;
              tx_ready <= 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  rx_state_t            rx_state;
  logic                 rx_meta, rx_sync;
  logic [DIV_W-1:0]     rx_div;
  logic [OS_W-1:0]      rx_tcnt;
  logic [BIT_W-1:0]     rx_bit;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_en, rx_par_odd, rx_par_bad;
  logic                 rx_tick, rx_sample;

  assign rx_tick   = (rx_div == DIV_MAX);
  // START samples at mid start bit; later states sample one bit period apart.
  assign rx_sample = rx_tick && (rx_tcnt == ((rx_state == RX_START) ? OS_HALF : OS_MAX));
  assign rx_busy   = (rx_state != RX_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state      <= RX_IDLE;
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_div        <= '0;
      rx_tcnt       <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_par_en     <= 1'b0;
      rx_par_odd    <= 1'b0;
      rx_par_bad    <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      if (rx_state != RX_IDLE) begin
        rx_div <= rx_tick ? '0 : rx_div + 1'b1;
        if (rx_tick) rx_tcnt <= rx_sample ? '0 : rx_tcnt + 1'b1;
      end
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state   <= RX_START;
            rx_div     <= '0;
            rx_tcnt    <= '0;
            rx_par_en  <= par_sel;
            rx_par_odd <= par_odd;
          end
        end
        RX_START: begin
          if (rx_sample) begin
            rx_state <= rx_sync ? RX_IDLE : RX_DATA;
            rx_bit   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_sample) begin
            rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
            if (rx_bit == BIT_MAX) rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
            else                   rx_bit   <= rx_bit + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_sample) begin
            rx_par_bad <= rx_sync ^ (^rx_shift) ^ rx_par_odd;
            rx_state   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_sample) begin
            if (rx_sync) begin
              rx_data       <= rx_shift;
              rx_valid      <= 1'b1;
              rx_parity_err <= rx_par_en & rx_par_bad;
              rx_state      <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT_IDLE;
            end
          end
        end
        RX_WAIT_IDLE: if (rx_sync) rx_state <= RX_IDLE;
        default:      rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
